// File: rtl/rom_rd_pkg.sv
// Shared types and default sizes for the ROM burst reader.
//   state_t      : burst controller states
//   fifo_entry_t : one output FIFO entry, {last tag, ROM data word}
//   ADDR_W/DATA_W: default ROM address and data widths
package rom_rd_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous FIFO with occupancy count, first-word-fall-through head.
// Ports:
//   clk, rst   : clock, synchronous active-low reset (empties FIFO, clears storage)
//   wr_en      : push wr_data (ignored when full and not popping)
//   rd_en      : pop head when non-empty
//   rd_data    : current head entry (zero after reset)
//   empty      : no entries held
//   count      : number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module rom_rd_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    // Handshake qualification
    always_comb begin
        full_s = (count_r == (PTR_W+1)'(DEPTH));
        pop_s  = rd_en && (count_r != {(PTR_W+1){1'b0}});
        push_s = wr_en && (!full_s || pop_s);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (count_r == {(PTR_W+1){1'b0}});
    assign count   = count_r;

    rom_rd_fifo_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .full  (full_s)
    );

endmodule

// File: rtl/rom_rd_fifo_chk.sv
// Checker for rom_rd_fifo: a write into a full FIFO without a simultaneous
// read would lose a word, which the credit scheme upstream must prevent.
// Ports: clk, rst (sync, active-low), wr_en, rd_en, full.
module rom_rd_fifo_chk (
    input logic clk,
    input logic rst,
    input logic wr_en,
    input logic rd_en,
    input logic full
);

    // Overflow guard
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(wr_en && full && !rd_en));

endmodule

// File: rtl/rom_burst_reader.sv
// Burst reader in front of a registered-read lookup ROM. A start request
// issues len sequential addresses from base_addr (wrapping at the top of the
// address space); returned words are captured into an output FIFO and
// presented as a valid/ready stream with a last-word flag. Addresses are only
// issued while FIFO occupancy plus words in flight leaves room, so the ROM is
// never stalled and no returned word is dropped.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start             : burst request, sampled only in IDLE
//   base_addr, len    : first address and word count (len 0 = empty burst)
//   busy, done        : burst in progress / one-cycle completion pulse
//   rom_addr          : address to the ROM (holds last issued value)
//   rom_data          : ROM registered read data
//   m_data/m_valid/m_ready/m_last : output stream
//   word_cnt          : saturating handshake count since reset
//                       (present only with ROM_RD_WORD_CNT_EN defined)
module rom_burst_reader #(
    parameter int ADDR_W     = rom_rd_pkg::ADDR_W,
    parameter int DATA_W     = rom_rd_pkg::DATA_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef ROM_RD_WORD_CNT_EN
    output logic              m_last,
    output logic [15:0]       word_cnt
`else
    output logic              m_last
`endif
);

    import rom_rd_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] addr_q_r;
    logic [ADDR_W-1:0] remain_r;
    logic [ADDR_W-1:0] rom_addr_hold_r;
    logic [RD_LAT-1:0] pipe_vld_r;
    logic [RD_LAT-1:0] pipe_last_r;
    logic              busy_r;
    logic              done_r;
    logic              issue_s;
    logic              credit_ok_s;
    logic [CNT_W-1:0]  inflight_s;
    logic [CNT_W:0]    used_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    fifo_entry_t       wr_entry_s;
    fifo_entry_t       rd_entry_s;

    // Words in flight and credit check against FIFO capacity
    always_comb begin
        inflight_s = {CNT_W{1'b0}};
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + {{(CNT_W-1){1'b0}}, pipe_vld_r[i]};
        end
        used_s      = {1'b0, fifo_count_s} + {1'b0, inflight_s};
        credit_ok_s = (used_s < (CNT_W+1)'(FIFO_DEPTH));
    end

    // Next-state and issue decision
    always_comb begin
        state_nx_s = state_r;
        issue_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len == {ADDR_W{1'b0}}) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = ISSUE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (credit_ok_s) begin
                    issue_s = 1'b1;
                    if (remain_r == ADDR_W'(1)) begin
                        state_nx_s = DRAIN;
                    end else begin
                        state_nx_s = ISSUE;
                    end
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            DRAIN: begin
                if ((inflight_s == {CNT_W{1'b0}}) && fifo_empty_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state, burst address/remaining counters, status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= IDLE;
            addr_q_r        <= {ADDR_W{1'b0}};
            remain_r        <= {ADDR_W{1'b0}};
            rom_addr_hold_r <= {ADDR_W{1'b0}};
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            done_r  <= (state_nx_s == DONE);
            if ((state_r == IDLE) && start && (len != {ADDR_W{1'b0}})) begin
                addr_q_r <= base_addr;
                remain_r <= len;
            end else if (issue_s) begin
                addr_q_r        <= addr_q_r + ADDR_W'(1);
                remain_r        <= remain_r - ADDR_W'(1);
                rom_addr_hold_r <= addr_q_r;
            end else begin
                addr_q_r <= addr_q_r;
                remain_r <= remain_r;
            end
        end
    end

    // In-flight pipe: one stage per cycle of ROM read latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld_r  <= {RD_LAT{1'b0}};
            pipe_last_r <= {RD_LAT{1'b0}};
        end else begin
            pipe_vld_r[0]  <= issue_s;
            pipe_last_r[0] <= issue_s && (remain_r == ADDR_W'(1));
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_last_r[i] <= pipe_last_r[i-1];
            end
        end
    end

    // ROM address: the live counter during an issue cycle so the ROM samples
    // it at the same edge the word enters the pipe; otherwise the last issued
    // address is held.
    always_comb begin
        if (issue_s) begin
            rom_addr = addr_q_r;
        end else begin
            rom_addr = rom_addr_hold_r;
        end
    end

    // FIFO write entry from the pipe output stage
    always_comb begin
        wr_entry_s.last = pipe_last_r[RD_LAT-1];
        wr_entry_s.data = rom_data;
    end

    rom_rd_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pipe_vld_r[RD_LAT-1]),
        .wr_data (wr_entry_s),
        .rd_en   (m_ready),
        .rd_data (rd_entry_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign m_valid = !fifo_empty_s;
    assign m_data  = rd_entry_s.data;
    assign m_last  = rd_entry_s.last;
    assign busy    = busy_r;
    assign done    = done_r;

`ifdef ROM_RD_WORD_CNT_EN
    logic [15:0] word_cnt_r;

    // Saturating stream handshake counter, never cleared between bursts
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt_r <= 16'd0;
        end else if (m_valid && m_ready && (word_cnt_r != 16'hFFFF)) begin
            word_cnt_r <= word_cnt_r + 16'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign word_cnt = word_cnt_r;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader with a behavioural 256x4 ROM
// (1-cycle registered read). Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge.
module tb_rom_burst_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
`ifdef ROM_RD_WORD_CNT_EN
    logic [15:0] word_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_burst_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
`ifdef ROM_RD_WORD_CNT_EN
        .m_last    (m_last),
        .word_cnt  (word_cnt)
`else
        .m_last    (m_last)
`endif
    );

    // ROM contents: known words at 1..5, a fixed pattern elsewhere
    function automatic logic [3:0] rom_f(input logic [7:0] a);
        case (a)
            8'h01:   return 4'h6;
            8'h02:   return 4'hC;
            8'h03:   return 4'hE;
            8'h04:   return 4'h5;
            8'h05:   return 4'h9;
            default: return a[3:0] ^ 4'hA;
        endcase
    endfunction

    // Registered ROM read
    always @(posedge clk) rom_data <= rom_f(rom_addr);

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, row, act, exp);
        end
    endtask

    typedef struct {
        logic       start;
        logic [7:0] base;
        logic [7:0] len;
        logic       busy;
        logic       done;
        logic [7:0] addr;
        logic       valid;
        logic [3:0] data;
        logic       last;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [7:0] b, input logic [7:0] l,
                                input logic bz, input logic dn, input logic [7:0] ad,
                                input logic v, input logic [3:0] d, input logic lt);
        vec_t r;
        r.start = st; r.base = b; r.len = l; r.busy = bz; r.done = dn;
        r.addr = ad; r.valid = v; r.data = d; r.last = lt;
        return r;
    endfunction

    logic [3:0] got_d[$];
    logic       got_l[$];
    bit         done_seen;

    // Gather handshaken words until done or the cycle budget runs out
    task automatic collect(input int max_cyc);
        got_d.delete();
        got_l.delete();
        done_seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_stream(input string name, input logic [7:0] base, input int n);
        chk({name, " done"}, 0, 32'(done_seen), 32'd1);
        chk({name, " count"}, 0, 32'(got_d.size()), 32'(n));
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            chk({name, " data"}, i, 32'(got_d[i]), 32'(rom_f(a)));
            chk({name, " last"}, i, 32'(got_l[i]), 32'(i == n - 1));
        end
        // Back in IDLE the cycle after done
        @(posedge clk); #1;
        chk({name, " busy after done"}, 0, 32'(busy), 32'd0);
    endtask

    task automatic start_burst(input logic [7:0] b, input logic [7:0] l);
        @(negedge clk);
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    vec_t tbl[21];
    bit   any_done;

    initial begin
        // Two bursts base=1/len=5: the second also pulses start mid-burst,
        // in DRAIN, and in the done cycle (all ignored).
        tbl[0]  = mk(1'b1, 8'h01, 8'd5, 1'b1, 1'b0, 8'h01, 1'b0, 4'h0, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h02, 1'b0, 4'h0, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h03, 1'b1, 4'h6, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h04, 1'b1, 4'hC, 1'b0);
        tbl[4]  = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h05, 1'b1, 4'hE, 1'b0);
        tbl[5]  = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h05, 1'b1, 4'h5, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h05, 1'b1, 4'h9, 1'b1);
        tbl[7]  = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h05, 1'b0, 4'h0, 1'b0);
        tbl[8]  = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b1, 8'h05, 1'b0, 4'h0, 1'b0);
        tbl[9]  = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h05, 1'b0, 4'h0, 1'b0);
        tbl[10] = mk(1'b1, 8'h01, 8'd5, 1'b1, 1'b0, 8'h01, 1'b0, 4'h0, 1'b0);
        tbl[11] = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h02, 1'b0, 4'h0, 1'b0);
        tbl[12] = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h03, 1'b1, 4'h6, 1'b0);
        tbl[13] = mk(1'b1, 8'h03, 8'd5, 1'b1, 1'b0, 8'h04, 1'b1, 4'hC, 1'b0);
        tbl[14] = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h05, 1'b1, 4'hE, 1'b0);
        tbl[15] = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h05, 1'b1, 4'h5, 1'b0);
        tbl[16] = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 8'h05, 1'b1, 4'h9, 1'b1);
        tbl[17] = mk(1'b1, 8'h03, 8'd2, 1'b1, 1'b0, 8'h05, 1'b0, 4'h0, 1'b0);
        tbl[18] = mk(1'b0, 8'h00, 8'd0, 1'b1, 1'b1, 8'h05, 1'b0, 4'h0, 1'b0);
        tbl[19] = mk(1'b1, 8'h03, 8'd5, 1'b0, 1'b0, 8'h05, 1'b0, 4'h0, 1'b0);
        tbl[20] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 8'h05, 1'b0, 4'h0, 1'b0);

        rst = 1'b0; start = 1'b0; base_addr = 8'h00; len = 8'h00; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",   0, 32'(busy),     32'd0);
        chk("reset done",   0, 32'(done),     32'd0);
        chk("reset valid",  0, 32'(m_valid),  32'd0);
        chk("reset addr",   0, 32'(rom_addr), 32'd0);
        chk("reset data",   0, 32'(m_data),   32'd0);
        chk("reset last",   0, 32'(m_last),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven bursts
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            start = tbl[i].start; base_addr = tbl[i].base; len = tbl[i].len; m_ready = 1'b1;
            @(posedge clk); #1;
            chk("tbl busy",  i, 32'(busy),     32'(tbl[i].busy));
            chk("tbl done",  i, 32'(done),     32'(tbl[i].done));
            chk("tbl addr",  i, 32'(rom_addr), 32'(tbl[i].addr));
            chk("tbl valid", i, 32'(m_valid),  32'(tbl[i].valid));
            if (tbl[i].valid) begin
                chk("tbl data", i, 32'(m_data), 32'(tbl[i].data));
                chk("tbl last", i, 32'(m_last), 32'(tbl[i].last));
            end
        end
        @(negedge clk);
        start = 1'b0;

        // Backpressure: 10 stalled cycles, only 4 addresses may be issued
        m_ready = 1'b0;
        start_burst(8'h01, 8'd5);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            chk("bp addr", c, 32'(rom_addr), (c < 4) ? 32'(c + 1) : 32'd4);
            chk("bp valid", c, 32'(m_valid), 32'(c >= 2));
            if (c >= 2) chk("bp data held", c, 32'(m_data), 32'h6);
        end
        m_ready = 1'b1;
        collect(40);
        check_stream("bp stream", 8'h01, 5);

        // Address wrap FE, FF, 00
        start_burst(8'hFE, 8'd3);
        chk("wrap addr", 0, 32'(rom_addr), 32'hFE);
        @(posedge clk); #1;
        chk("wrap addr", 1, 32'(rom_addr), 32'hFF);
        @(posedge clk); #1;
        chk("wrap addr", 2, 32'(rom_addr), 32'h00);
        collect(20);
        check_stream("wrap stream", 8'hFE, 3);

        // Empty burst
        start_burst(8'h77, 8'd0);
        chk("empty done",  0, 32'(done),     32'd1);
        chk("empty busy",  0, 32'(busy),     32'd1);
        chk("empty valid", 0, 32'(m_valid),  32'd0);
        chk("empty addr",  0, 32'(rom_addr), 32'h00);
        @(posedge clk); #1;
        chk("empty done",  1, 32'(done),     32'd0);
        chk("empty busy",  1, 32'(busy),     32'd0);
        chk("empty valid", 1, 32'(m_valid),  32'd0);
        chk("empty addr",  1, 32'(rom_addr), 32'h00);

        // Reset mid-burst after two words
        start_burst(8'h01, 8'd5);
        repeat (4) @(posedge clk);
        #1;
        chk("mid data", 4, 32'(m_data), 32'hE);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid-rst busy",  0, 32'(busy),     32'd0);
        chk("mid-rst done",  0, 32'(done),     32'd0);
        chk("mid-rst valid", 0, 32'(m_valid),  32'd0);
        chk("mid-rst addr",  0, 32'(rom_addr), 32'd0);
        chk("mid-rst data",  0, 32'(m_data),   32'd0);
        chk("mid-rst last",  0, 32'(m_last),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        any_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || m_valid) any_done = 1'b1;
        end
        chk("no done after reset", 0, 32'(any_done), 32'd0);
        start_burst(8'h04, 8'd2);
        collect(20);
        check_stream("post-rst stream", 8'h04, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
